i2c_master_controller: RTL

- I2C bus master that initiates one complete transaction toward a slave memory.
- Sequence: START, address + R/W bit, NBYTES data bytes (written to or read from the slave), STOP.
- Drives open-drain SCL/SDA enables from a single system clock.
- Sits between the host/test logic and the bus; it is the initiating end for the slave memory block.

---
 rtl/i2c_master_controller.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_controller.sv
// i2c_master_controller: single-transaction I2C bus master.
// START, address + R/W, NBYTES data bytes (write or read), STOP, then Done.
// Optional feature macro: I2C_MASTER_CLOCK_STRETCH_EN (slave clock stretching on SCL_I).
module i2c_master_controller #(
    parameter int ADDRESSLENGTH = 7,
    parameter int NBYTES        = 4,
    parameter int CLKDIV        = 250
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Start,
    input  logic                       RorW,
    input  logic [ADDRESSLENGTH-1:0]   Address,
    input  logic [8*NBYTES-1:0]        WriteData,
    output logic [8*NBYTES-1:0]        ReadData,
    output logic                       Busy,
    output logic                       Done,
    output logic                       AckError,
    output logic                       SCL_O,
    output logic                       SDA_O,
    input  logic                       SDA_I,
    input  logic                       SCL_I
);

    localparam int CW = $clog2(CLKDIV);
    localparam int BW = $clog2(((ADDRESSLENGTH > 7) ? ADDRESSLENGTH : 7) + 1);
    localparam int YW = $clog2(NBYTES) + 1;
    localparam logic [CW-1:0] CMAX = CW'(CLKDIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA,
        S_WACK, S_RDATA, S_RACK, S_STOP, S_DONE
    } state_t;

    state_t            state, state_n;
    logic [1:0]        q, q_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [BW-1:0]     bitcnt, bitcnt_n;
    logic [YW-1:0]     bytecnt, bytecnt_n;

    logic [ADDRESSLENGTH:0] ash;
    logic                   rw_l;
    logic [8*NBYTES-1:0]    wsh;
    logic [7:0]             rx;
    logic [8*NBYTES-1:0]    rdata;
    logic                   ackerr;

    logic active, in_slot, run, tick, qend;
    logic scl, sda;

    assign active  = (state != S_IDLE) && (state != S_DONE);
    assign in_slot = state inside {S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK};

`ifdef I2C_MASTER_CLOCK_STRETCH_EN
    // While SCL is released (q2/q3) a slave holding the line low freezes the quarter counter.
    assign run = !(in_slot && q[1] && !SCL_I);
`else
    logic unused_scl;
    assign unused_scl = SCL_I;
    assign run = 1'b1;
`endif

    assign tick = active && run && (cnt == CMAX);
    assign qend = tick && (q == 2'd3);

    assign SCL_O    = scl;
    assign SDA_O    = sda;
    assign Busy     = (state != S_IDLE);
    assign Done     = (state == S_DONE);
    assign AckError = ackerr;
    assign ReadData = rdata;

    // State register: FSM state, quarter phase, quarter counter, bit and byte counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            q       <= '0;
            cnt     <= '0;
            bitcnt  <= '0;
            bytecnt <= '0;
        end else begin
            state   <= state_n;
            q       <= q_n;
            cnt     <= cnt_n;
            bitcnt  <= bitcnt_n;
            bytecnt <= bytecnt_n;
        end
    end

    // Next-state sequencing and bus line levels for each state/quarter.
    always_comb begin
        state_n   = state;
        q_n       = q;
        cnt_n     = cnt;
        bitcnt_n  = bitcnt;
        bytecnt_n = bytecnt;
        scl       = 1'b1;
        sda       = 1'b1;

        if (!active)
            cnt_n = '0;
        else if (run)
            cnt_n = tick ? '0 : cnt + CW'(1);

        if (tick)
            q_n = q + 2'd1;

        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_n   = S_START;
                    q_n       = '0;
                    bitcnt_n  = '0;
                    bytecnt_n = '0;
                end
            end
            S_START: begin
                scl = (q != 2'd3);
                sda = (q == 2'd0);
                if (qend) begin
                    state_n  = S_ADDR;
                    bitcnt_n = '0;
                end
            end
            S_ADDR: begin
                scl = q[1];
                sda = ash[ADDRESSLENGTH];
                if (qend) begin
                    if (bitcnt == BW'(ADDRESSLENGTH)) begin
                        state_n  = S_AACK;
                        bitcnt_n = '0;
                    end else begin
                        bitcnt_n = bitcnt + BW'(1);
                    end
                end
            end
            S_AACK: begin
                scl = q[1];
                if (qend) begin
                    bitcnt_n  = '0;
                    bytecnt_n = '0;
                    if (ackerr)
                        state_n = S_STOP;
                    else if (rw_l)
                        state_n = S_WDATA;
                    else
                        state_n = S_RDATA;
                end
            end
            S_WDATA: begin
                scl = q[1];
                sda = wsh[7];
                if (qend) begin
                    if (bitcnt == BW'(7)) begin
                        state_n  = S_WACK;
                        bitcnt_n = '0;
                    end else begin
                        bitcnt_n = bitcnt + BW'(1);
                    end
                end
            end
            S_WACK: begin
                scl = q[1];
                if (qend) begin
                    if (ackerr || (bytecnt == YW'(NBYTES - 1))) begin
                        state_n = S_STOP;
                    end else begin
                        state_n   = S_WDATA;
                        bytecnt_n = bytecnt + YW'(1);
                    end
                end
            end
            S_RDATA: begin
                scl = q[1];
                if (qend) begin
                    if (bitcnt == BW'(7)) begin
                        state_n  = S_RACK;
                        bitcnt_n = '0;
                    end else begin
                        bitcnt_n = bitcnt + BW'(1);
                    end
                end
            end
            S_RACK: begin
                scl = q[1];
                sda = (bytecnt == YW'(NBYTES - 1));
                if (qend) begin
                    if (bytecnt == YW'(NBYTES - 1)) begin
                        state_n = S_STOP;
                    end else begin
                        state_n   = S_RDATA;
                        bytecnt_n = bytecnt + YW'(1);
                    end
                end
            end
            S_STOP: begin
                scl = (q != 2'd0);
                sda = q[1];
                if (qend)
                    state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Datapath: request latching, bit shifting, SDA sampling, ACK error and read result capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ash    <= '0;
            rw_l   <= 1'b0;
            wsh    <= '0;
            rx     <= '0;
            rdata  <= '0;
            ackerr <= 1'b0;
        end else begin
            if ((state == S_IDLE) && Start) begin
                ash    <= {Address, ~RorW};
                rw_l   <= RorW;
                wsh    <= WriteData;
                ackerr <= 1'b0;
            end
            if (tick && (q == 2'd2)) begin
                if (state == S_RDATA)
                    rx <= {rx[6:0], SDA_I};
                if (((state == S_AACK) || (state == S_WACK)) && SDA_I)
                    ackerr <= 1'b1;
            end
            if (qend) begin
                case (state)
                    S_ADDR:  ash <= {ash[ADDRESSLENGTH-1:0], 1'b0};
                    // Low byte shifts per bit; whole payload drops a byte after each ACK slot.
                    S_WDATA: wsh[7:0] <= {wsh[6:0], 1'b0};
                    S_WACK:  wsh <= wsh >> 8;
                    S_RDATA: begin
                        if (bitcnt == BW'(7)) begin
                            for (int unsigned k = 0; k < NBYTES; k++) begin
                                if (bytecnt == YW'(k))
                                    rdata[8*k +: 8] <= rx;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
